// File: rtl/dna_pkg.sv
// Shared types for the DNA deletion-correction datapath.
// Digits are 2-bit symbols; indices travel as 7-bit values.
package dna_pkg;

  typedef logic [1:0] digit_t;

  localparam int IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } del_state_t;

endpackage

// File: rtl/delete_digit.sv
// Removes one 2-bit digit from an (N+1)-digit word, one digit per clock.
// Inverse of insert_digit: returns the N-digit word and the removed digit.
module delete_digit
  import dna_pkg::*;
#(
  parameter int N = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N+1:0]     word_in,
  input  logic [IDX_W-1:0]   delete_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     word_out,
  output logic [1:0]         deleted_digit,
  output logic               idx_err
);

  localparam int CW = $clog2(N + 1);

  del_state_t state_q, state_d;

  logic [N:0][1:0]   src_q;
  logic [N-1:0][1:0] wout_q;
  digit_t            del_q;
  logic              err_q;
  logic              ov_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     p_q;

  logic              in_fire;
  logic              bad_idx;
  logic              last;
  logic [IDX_W-1:0]  p_full;
  logic [CW-1:0]     sel;

  assign in_fire = in_valid & in_ready;
  assign bad_idx = delete_index > IDX_W'(N - 1);
  assign last    = cnt_q == CW'(N - 1);
  assign p_full  = IDX_W'(N - 1) - delete_index;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_fire) state_d = bad_idx ? DONE : SHIFT;
      SHIFT:   if (last) state_d = DONE;
      DONE:    if (ov_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = state_q == IDLE;
    sel      = (cnt_q < p_q) ? cnt_q : cnt_q + CW'(1);
  end

  // An index error enters DONE directly, so out_valid lags one cycle there.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      wout_q <= '0;
      del_q  <= '0;
      err_q  <= 1'b0;
      ov_q   <= 1'b0;
      cnt_q  <= '0;
      p_q    <= '0;
    end else begin
      ov_q <= (state_q != IDLE) && (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (in_fire && bad_idx) begin
            wout_q <= word_in[2*N-1:0];
            del_q  <= '0;
            err_q  <= 1'b1;
          end else if (in_fire) begin
            src_q <= word_in;
            p_q   <= p_full[CW-1:0];
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        SHIFT: begin
          wout_q[cnt_q] <= src_q[sel];
          if (cnt_q == p_q) del_q <= src_q[p_q];
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = ov_q;
  assign word_out      = wout_q;
  assign deleted_digit = del_q;
  assign idx_err       = err_q;

endmodule

// File: tb/tb_delete_digit.sv
// Self-checking bench for delete_digit (N=6).
// Random round-trips go through a queue-based insert_digit model.
module tb_delete_digit;
  import dna_pkg::*;

  localparam int N = 6;
  localparam logic [2*N+1:0] W = 14'b11_10_01_00_11_10_01;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2*N+1:0]   word_in;
  logic [IDX_W-1:0] delete_index;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   word_out;
  logic [1:0]       deleted_digit;
  logic             idx_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  delete_digit #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .word_in(word_in),
    .delete_index(delete_index),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .word_out(word_out),
    .deleted_digit(deleted_digit),
    .idx_err(idx_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*N+1:0] model_insert(
    input logic [2*N-1:0] w, input int k, input logic [1:0] d);
    logic [1:0] q[$];
    logic [2*N+1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) q.push_back(w[2*i+:2]);
    q.insert(N - 1 - k, d);
    for (int i = 0; i <= N; i++) r[2*i+:2] = q[i];
    return r;
  endfunction

  task automatic model_delete(
    input logic [2*N+1:0] word, input logic [6:0] idx,
    output logic [2*N-1:0] wo, output logic [1:0] dg,
    output logic er);
    logic [1:0] q[$];
    int p;
    wo = '0;
    if (int'(idx) > N - 1) begin
      wo = word[2*N-1:0];
      dg = 2'b00;
      er = 1'b1;
    end else begin
      for (int i = 0; i <= N; i++) q.push_back(word[2*i+:2]);
      p = N - 1 - int'(idx);
      dg = q[p];
      q.delete(p);
      for (int i = 0; i < N; i++) wo[2*i+:2] = q[i];
      er = 1'b0;
    end
  endtask

  task automatic send(input logic [2*N+1:0] w, input logic [6:0] idx);
    int n;
    n = 0;
    word_in = w;
    delete_index = idx;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int k, input bit rnd);
    k = 0;
    while (!out_valid && k < 50) begin
      out_ready = rnd ? 1'($urandom) : 1'b0;
      tick;
      k++;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout out_valid=%b want=1", out_valid);
    end
  endtask

  task automatic take;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    word_in = '0;
    delete_index = '0;
    tick;
    tick;
    checks++;
    if ({in_ready, out_valid, word_out, deleted_digit, idx_err} !==
        {1'b1, 1'b0, 12'h000, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL reset got rdy=%b ov=%b w=%h d=%h e=%b want 1 0 000 0 0",
               in_ready, out_valid, word_out, deleted_digit, idx_err);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_mid_delete;
    int k;
    send(W, 7'd0);
    wait_valid(k, 0);
    checks++;
    if (k !== N) begin
      errors++;
      $display("FAIL idx0_latency got=%0d want=%0d", k, N);
    end
    checks++;
    if ({word_out, deleted_digit, idx_err} !== {12'hD39, 2'b10, 1'b0}) begin
      errors++;
      $display("FAIL idx0_result got w=%h d=%h e=%b want D39 2 0",
               word_out, deleted_digit, idx_err);
    end
    take;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idx0_release ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_p0;
    int k;
    send(W, 7'd5);
    wait_valid(k, 0);
    checks++;
    if (k !== N) begin
      errors++;
      $display("FAIL idx5_latency got=%0d want=%0d", k, N);
    end
    checks++;
    if ({word_out, deleted_digit, idx_err} !== {12'hE4E, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL idx5_result got w=%h d=%h e=%b want E4E 1 0",
               word_out, deleted_digit, idx_err);
    end
    take;
  endtask

  task automatic test_idx_err;
    int k;
    logic [6:0] idxs [2];
    idxs[0] = 7'd6;
    idxs[1] = 7'd100;
    for (int i = 0; i < 2; i++) begin
      send(W, idxs[i]);
      wait_valid(k, 0);
      checks++;
      if (k !== 1) begin
        errors++;
        $display("FAIL err_latency idx=%0d got=%0d want=1", idxs[i], k);
      end
      checks++;
      if ({word_out, deleted_digit, idx_err} !== {12'h939, 2'b00, 1'b1}) begin
        errors++;
        $display("FAIL err_result idx=%0d got w=%h d=%h e=%b want 939 0 1",
                 idxs[i], word_out, deleted_digit, idx_err);
      end
      take;
    end
  endtask

  task automatic test_backpressure;
    int k;
    logic [2*N+1:0] w2;
    logic [6:0] i2;
    logic [2*N-1:0] ew;
    logic [1:0] ed;
    logic ee;
    w2 = 14'($urandom);
    i2 = 7'($urandom_range(0, N - 1));
    model_delete(w2, i2, ew, ed, ee);
    send(W, 7'd0);
    wait_valid(k, 0);
    word_in = w2;
    delete_index = i2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if ({out_valid, in_ready, word_out, deleted_digit, idx_err} !==
          {1'b1, 1'b0, 12'hD39, 2'b10, 1'b0}) begin
        errors++;
        $display("FAIL hold c=%0d got ov=%b rdy=%b w=%h d=%h e=%b want 1 0 D39 2 0",
                 c, out_valid, in_ready, word_out, deleted_digit, idx_err);
      end
    end
    take;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
    tick;
    in_valid = 1'b0;
    wait_valid(k, 0);
    checks++;
    if (k !== N || {word_out, deleted_digit, idx_err} !== {ew, ed, ee}) begin
      errors++;
      $display("FAIL second_word got k=%0d w=%h d=%h e=%b want k=%0d w=%h d=%h e=%b",
               k, word_out, deleted_digit, idx_err, N, ew, ed, ee);
    end
    take;
  endtask

  task automatic test_reset_mid;
    int k;
    send(W, 7'd0);
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      tick;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_leak c=%0d ov=%b want 0", c, out_valid);
      end
    end
    send(W, 7'd5);
    wait_valid(k, 0);
    checks++;
    if (k !== N || {word_out, deleted_digit, idx_err} !== {12'hE4E, 2'b01, 1'b0}) begin
      errors++;
      $display("FAIL after_reset got k=%0d w=%h d=%h e=%b want 6 E4E 1 0",
               k, word_out, deleted_digit, idx_err);
    end
    take;
  endtask

  task automatic test_back_to_back(input logic [6:0] idx, input int gap);
    int acc[$];
    int k;
    logic [2*N-1:0] ew;
    logic [1:0] ed;
    logic ee;
    model_delete(W, idx, ew, ed, ee);
    word_in = W;
    delete_index = idx;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && acc.size() < 3; c++) begin
      if (in_ready) acc.push_back(c);
      if (out_valid) begin
        checks++;
        if ({word_out, deleted_digit, idx_err} !== {ew, ed, ee}) begin
          errors++;
          $display("FAIL b2b_result idx=%0d got w=%h d=%h e=%b want w=%h d=%h e=%b",
                   idx, word_out, deleted_digit, idx_err, ew, ed, ee);
        end
      end
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (acc.size() < 3 || acc[1] - acc[0] != gap || acc[2] - acc[1] != gap) begin
      errors++;
      $display("FAIL b2b_gap idx=%0d got n=%0d gaps=%0d,%0d want %0d",
               idx, acc.size(), acc[1] - acc[0], acc[2] - acc[1], gap);
    end
    wait_valid(k, 0);
    take;
  endtask

  task automatic test_random;
    int k;
    int kk;
    logic [2*N-1:0] w;
    logic [1:0] d;
    for (int it = 0; it < 1000; it++) begin
      w = 12'($urandom);
      k = $urandom_range(0, N - 1);
      d = 2'($urandom);
      send(model_insert(w, k, d), 7'(k));
      wait_valid(kk, 1);
      checks++;
      if ({word_out, deleted_digit, idx_err} !== {w, d, 1'b0}) begin
        errors++;
        $display("FAIL roundtrip it=%0d k=%0d got w=%h d=%h e=%b want w=%h d=%h e=0",
                 it, k, word_out, deleted_digit, idx_err, w, d);
      end
      repeat ($urandom_range(0, 3)) tick;
      take;
    end
  endtask

  initial begin
    test_reset;
    test_mid_delete;
    test_p0;
    test_idx_err;
    test_backpressure;
    test_reset_mid;
    test_back_to_back(7'd0, N + 2);
    test_back_to_back(7'd6, 3);
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
